pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Consumer-side companion to the PLL wrapper. Runs on the PLL reference clock, drives the PLL `rst` input, watches the PLL `locked` output, and produces a qualified, glitch-free reset and ready indication for the OFDM datapath. It retries the PLL when lock never arrives and re-sequences when lock is lost.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: width of each PLL reset pulse in `refclk` cycles (≥2).
- `LOCK_TIMEOUT`, default 65536: cycles to wait for `locked` before retrying the PLL (≥2).
- `STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before release (≥2).
- `SYNC_STAGES`, default 2: synchronizer depth on `locked` (≥2).

Ports:
- `refclk` in 1: the single clock (PLL reference clock, 310 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL.
- `sys_rst` out 1: active-high reset to the downstream datapath.
- `ready` out 1: high only in RUN.
- `state` out 2: current state encoding.
- `retry_cnt` out 8: number of timeout retries, saturating at 255.
- `loss_cnt` out 16: lock-loss events, present only with `PLL_LOSS_COUNT_EN`.

## Operation
- `locked` passes through a `SYNC_STAGES` flip-flop chain to give `locked_s`. No other logic reads raw `locked`.
- One shared cycle counter `cnt` drives the FSM. Its width is `$clog2` of the largest of the three cycle parameters. It clears to 0 on every state entry.
- FSM states and encodings:
  - PLL_RST (0): hold `pll_rst`=1. When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK (1):
    - `locked_s`=1: go to STABLE.
    - Otherwise, when `cnt`==LOCK_TIMEOUT-1: go to PLL_RST and increment `retry_cnt` (saturating).
  - STABLE (2):
    - `locked_s`=0: go back to WAIT_LOCK. The timeout restarts and no retry is counted.
    - When `cnt`==STABLE_CYCLES-1 with `locked_s`=1: go to RUN.
  - RUN (3): stay while `locked_s`=1. When `locked_s`=0, go to PLL_RST; with the macro enabled, also increment `loss_cnt` (saturating at 65535).
- Output decoding (all outputs registered from next-state, so they change in the same cycle as `state`):
  - `pll_rst` = (state==PLL_RST).
  - `sys_rst` = (state!=RUN).
  - `ready` = (state==RUN).
- `retry_cnt` and `loss_cnt` clear only on `rst`. They are never cleared by FSM transitions.

## Timing
- Reset values:
  - `state`=PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - `retry_cnt`=0, `loss_cnt`=0, `cnt`=0, synchronizer chain all 0.
- First PLL reset pulse: `pll_rst` stays high from reset assertion through exactly PLL_RST_CYCLES rising edges after `rst` deasserts.
- Lock-to-ready latency, with `locked` rising while in WAIT_LOCK: SYNC_STAGES + STABLE_CYCLES + 1 cycles from the first sampling edge to `ready`=1.
- Lock-loss response: `sys_rst`=1 and `ready`=0 appear SYNC_STAGES+1 cycles after `locked` falls. `pll_rst` rises in the same cycle.
- Timeout and loss in the same cycle cannot occur; the two conditions belong to different states.
- A `locked` glitch shorter than one cycle may or may not propagate. Either outcome only restarts STABLE, or forces a full re-sequence from RUN.
- `rst` asserted mid-operation returns everything to reset values immediately (asynchronous assertion). Deassertion is synchronous to `refclk`; the top-level reset synchronizer provides this.

## Configuration
- `PLL_LOSS_COUNT_EN`:
  - Defined: the `loss_cnt` port and its counter exist.
  - Undefined: both the port and the logic are removed. FSM behaviour is identical either way.

## Structure
- The shared package `pll_pkg` holds the state typedef, with literals PLL_RST=2'd0, WAIT_LOCK=2'd1, STABLE=2'd2, RUN=2'd3, plus the retry counter width constant (8).
- One sub-module, `sync_bit`: a parameterized-depth single-bit synchronizer with asynchronous active-high reset. It is reused for other crossings in the design.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=10, SYNC_STAGES=2.
- Reset release with `locked`=0 throughout:
  - `pll_rst` is high for 4 cycles, then low for 100 cycles.
  - The pattern repeats, and `retry_cnt` increments at each 4-cycle pulse.
  - `sys_rst` stays 1 and `ready` stays 0.
- `locked` rises 20 cycles into WAIT_LOCK and stays high: `ready`=1 and `sys_rst`=0 exactly 13 cycles after the first edge that samples `locked`=1. `retry_cnt`=0.
- `locked` drops for 3 cycles in the middle of STABLE:
  - FSM returns to WAIT_LOCK, then completes STABLE again.
  - `pll_rst` never reasserts and `retry_cnt` is unchanged.
- In RUN, `locked` falls:
  - 3 cycles later `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - `loss_cnt`=1 when the macro is defined.
- `rst` pulsed while in STABLE: all outputs return to reset values within the same cycle. The sequence restarts from PLL_RST.
- 260 consecutive timeouts: `retry_cnt` saturates at 255 and the FSM keeps retrying.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives PLL reset, qualifies PLL lock and produces datapath reset/ready.
// Optional lock-loss counter is enabled by defining PLL_LOSS_COUNT_EN.
module pll_lock_sequencer
  import pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [1:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q;
  logic               retry_inc;
  logic               locked_s;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (locked),
    .q  (locked_s)
  );

  // State, shared counter, registered outputs and retry counter.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      if (retry_inc && (retry_q != '1)) begin
        retry_q <= retry_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        // A dropout sends us back to WAIT_LOCK with a fresh timeout, not a retry.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLL_RST;
        end
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    pll_rst_d = (state_d == PLL_RST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef PLL_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_q;
  logic              loss_evt;

  assign loss_evt = (state_q == RUN) && !locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100,
// STABLE_CYCLES=10, SYNC_STAGES=2). Inputs change and outputs are sampled on negedges.
module tb_pll_lock_sequencer;

  logic        refclk;
  logic        rst;
  logic        locked;
  logic        pll_rst;
  logic        sys_rst;
  logic        ready;
  logic [1:0]  state;
  logic [7:0]  retry_cnt;
`ifdef PLL_LOSS_COUNT_EN
  logic [15:0] loss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic pll_seen;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (10),
    .SYNC_STAGES   (2)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .state    (state),
    .retry_cnt(retry_cnt)
`ifdef PLL_LOSS_COUNT_EN
    ,
    .loss_cnt (loss_cnt)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic        rst;
    logic        lk;
    int          adv;
    logic [1:0]  st;
    logic        pll;
    logic        sys;
    logic        rdy;
    logic [7:0]  retry;
    logic [15:0] loss;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      @(negedge refclk);
      if (pll_rst) pll_seen = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic pll,
                            input logic sys, input logic rdy, input logic [7:0] retry);
    check({tag, "_state"},   32'(state),     32'(st));
    check({tag, "_pll_rst"}, 32'(pll_rst),   32'(pll));
    check({tag, "_sys_rst"}, 32'(sys_rst),   32'(sys));
    check({tag, "_ready"},   32'(ready),     32'(rdy));
    check({tag, "_retry"},   32'(retry_cnt), 32'(retry));
  endtask

  initial begin
    rst      = 1'b1;
    locked   = 1'b0;
    pll_seen = 1'b0;

    //            rst   lk    adv  st     pll   sys   rdy   retry  loss
    // Timeout/retry cadence with locked low.
    vq.push_back('{1'b1, 1'b0, 1,   2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 3,   2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 1,   2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 99,  2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 1,   2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 16'd0});
    vq.push_back('{1'b0, 1'b0, 3,   2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 16'd0});
    vq.push_back('{1'b0, 1'b0, 1,   2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 16'd0});
    vq.push_back('{1'b0, 1'b0, 100, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2, 16'd0});
    // Fresh start; lock arrives 20 cycles into WAIT_LOCK (edge 1 = first sampling edge).
    vq.push_back('{1'b1, 1'b0, 1,   2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 4,   2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 20,  2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 1,   2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 1,   2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 1,   2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 9,   2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 1,   2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 50,  2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0});
    // Lock lost in RUN: response on the third edge.
    vq.push_back('{1'b0, 1'b0, 1,   2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 1,   2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 1,   2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1});
    vq.push_back('{1'b0, 1'b0, 4,   2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1});

    foreach (vq[i]) begin
      rst    = vq[i].rst;
      locked = vq[i].lk;
      repeat (vq[i].adv) @(posedge refclk);
      @(negedge refclk);
      $display("vec %0d: rst=%0b locked=%0b state=%0d pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d",
               i, rst, locked, state, pll_rst, sys_rst, ready, retry_cnt);
      check_outs($sformatf("v%0d", i), vq[i].st, vq[i].pll, vq[i].sys, vq[i].rdy, vq[i].retry);
`ifdef PLL_LOSS_COUNT_EN
      check($sformatf("v%0d_loss", i), 32'(loss_cnt), 32'(vq[i].loss));
`endif
    end

    // Dropout of 3 cycles in STABLE: back to WAIT_LOCK, PLL reset never reasserted.
    pll_seen = 1'b0;
    locked = 1'b1;
    tick(3);
    check("glitch_enter_stable", 32'(state), 32'd2);
    tick(4);
    locked = 1'b0;
    tick(2);
    check("glitch_still_stable", 32'(state), 32'd2);
    tick(1);
    check("glitch_back_wait", 32'(state), 32'd1);
    locked = 1'b1;
    tick(2);
    check("glitch_wait_hold", 32'(state), 32'd1);
    tick(1);
    check("glitch_restable", 32'(state), 32'd2);
    tick(9);
    check_outs("glitch_pre_run", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(1);
    check_outs("glitch_run", 2'd3, 1'b0, 1'b0, 1'b1, 8'd0);
    check("glitch_no_pll_rst", 32'(pll_seen), 32'd0);
    $display("seq glitch: state=%0d ready=%0b retry=%0d", state, ready, retry_cnt);

    // Asynchronous reset while in STABLE.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    check("arst_in_stable", 32'(state), 32'd2);
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check_outs("arst_now", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
`ifdef PLL_LOSS_COUNT_EN
    check("arst_loss", 32'(loss_cnt), 32'd0);
`endif
    @(negedge refclk);
    rst = 1'b0;
    tick(3);
    check("arst_restart_pll", 32'(state), 32'd0);
    tick(1);
    check("arst_restart_wait", 32'(state), 32'd1);
    tick(1);
    check("arst_restart_stable", 32'(state), 32'd2);
    $display("seq async reset: state=%0d pll_rst=%0b", state, pll_rst);

    // 260 consecutive timeouts: retry_cnt saturates at 255.
    rst    = 1'b1;
    locked = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      tick(104);
      check($sformatf("sat_state_%0d", k), 32'(state), 32'd0);
      check($sformatf("sat_retry_%0d", k), 32'(retry_cnt), (k > 255) ? 32'd255 : 32'(k));
    end
    check("sat_sys_rst", 32'(sys_rst), 32'd1);
    check("sat_ready", 32'(ready), 32'd0);
    tick(4);
    check("sat_still_retrying", 32'(state), 32'd1);
    $display("seq saturate: retry=%0d state=%0d", retry_cnt, state);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
